// File: rtl/cmos_dvp_capture.sv
// cmos_dvp_capture
// Camera-side DVP front end: registers the sensor bus, pairs bytes into
// RGB565 pixels, crops each frame to H_ACTIVE x V_ACTIVE, and drives the
// video FIFO write port plus its frame-sync. Single clock domain (pclk).
module cmos_dvp_capture #(
  parameter int H_ACTIVE    = 480,
  parameter int V_ACTIVE    = 272,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic [15:0] fifo_data_out,
  output logic        fifo_data_en,
  output logic        fifo_data_vs,
  output logic [7:0]  frame_cnt,
  output logic        line_err
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE);
  localparam logic [SW-1:0] SKIP_N = SW'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    SKIP    = 2'd1,
    ACTIVE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] skip_cnt_q, skip_cnt_d;

  // Registered sensor inputs and their one-cycle-delayed copies for edges.
  logic          s_vs_q, s_vs_d;
  logic          s_href_q, s_href_d;
  logic [7:0]    s_data_q, s_data_d;
  logic          s_vs_dly_q, s_vs_dly_d;
  logic          s_href_dly_q, s_href_dly_d;

  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [YW-1:0] y_cnt_q, y_cnt_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_byte_q, hi_byte_d;
  // Set when a frame starts mid-line; the rest of that line is discarded.
  logic          drop_q, drop_d;

  logic [15:0]   data_out_q, data_out_d;
  logic          data_en_q, data_en_d;
  logic          data_vs_q, data_vs_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          line_err_q, line_err_d;

  logic          vs_rise;
  logic          href_fall;
  logic          frame_start;
  logic          in_window;
  logic [SW-1:0] skip_inc;

  // Next-state logic: skip sequencing, frame/line bookkeeping, byte pairing.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    s_vs_d       = cmos_vsync;
    s_href_d     = cmos_href;
    s_data_d     = cmos_data;
    s_vs_dly_d   = s_vs_q;
    s_href_dly_d = s_href_q;

    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    phase_d      = phase_q;
    hi_byte_d    = hi_byte_q;
    drop_d       = drop_q;
    data_out_d   = data_out_q;
    data_en_d    = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    line_err_d   = line_err_q;

    vs_rise      = s_vs_q & ~s_vs_dly_q;
    href_fall    = s_href_dly_q & ~s_href_q;
    in_window    = (x_cnt_q < X_MAX) && (y_cnt_q < Y_MAX);
    skip_inc     = skip_cnt_q + 1'b1;
    frame_start  = 1'b0;

    case (state_q)
      WAIT_VS: begin
        if (vs_rise) begin
          if (skip_cnt_q < SKIP_N) begin
            state_d = SKIP;
          end else begin
            state_d     = ACTIVE;
            frame_start = 1'b1;
          end
        end
      end
      SKIP: begin
        if (vs_rise) begin
          skip_cnt_d = skip_inc;
          if (skip_inc == SKIP_N) begin
            state_d     = ACTIVE;
            frame_start = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (vs_rise) frame_start = 1'b1;
      end
      default: state_d = WAIT_VS;
    endcase

    if (frame_start) begin
      x_cnt_d     = '0;
      y_cnt_d     = '0;
      phase_d     = 1'b0;
      line_err_d  = 1'b0;
      frame_cnt_d = frame_cnt_q + 8'd1;
      drop_d      = s_href_q;
    end else if (state_q == ACTIVE) begin
      if (!s_href_q) begin
        phase_d = 1'b0;
        drop_d  = 1'b0;
        if (href_fall && !drop_q) begin
          x_cnt_d = '0;
          if (y_cnt_q < Y_MAX) y_cnt_d = y_cnt_q + 1'b1;
          if (phase_q || in_window) line_err_d = 1'b1;
        end
      end else if (!drop_q) begin
        if (!phase_q) begin
          hi_byte_d = s_data_q;
          phase_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (in_window) begin
            data_en_d  = 1'b1;
            data_out_d = {hi_byte_q, s_data_q};
          end
          if (x_cnt_q < X_MAX) x_cnt_d = x_cnt_q + 1'b1;
        end
      end
    end

    data_vs_d = (state_d == ACTIVE) & s_vs_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= WAIT_VS;
      skip_cnt_q   <= '0;
      s_vs_q       <= 1'b0;
      s_href_q     <= 1'b0;
      s_data_q     <= '0;
      s_vs_dly_q   <= 1'b0;
      s_href_dly_q <= 1'b0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      phase_q      <= 1'b0;
      hi_byte_q    <= '0;
      drop_q       <= 1'b0;
      data_out_q   <= '0;
      data_en_q    <= 1'b0;
      data_vs_q    <= 1'b0;
      frame_cnt_q  <= '0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      s_vs_q       <= s_vs_d;
      s_href_q     <= s_href_d;
      s_data_q     <= s_data_d;
      s_vs_dly_q   <= s_vs_dly_d;
      s_href_dly_q <= s_href_dly_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      phase_q      <= phase_d;
      hi_byte_q    <= hi_byte_d;
      drop_q       <= drop_d;
      data_out_q   <= data_out_d;
      data_en_q    <= data_en_d;
      data_vs_q    <= data_vs_d;
      frame_cnt_q  <= frame_cnt_d;
      line_err_q   <= line_err_d;
    end
  end

  assign fifo_data_out = data_out_q;
  assign fifo_data_en  = data_en_q;
  assign fifo_data_vs  = data_vs_q;
  assign frame_cnt     = frame_cnt_q;
  assign line_err      = line_err_q;

endmodule

// File: tb/tb_cmos_dvp_capture.sv
// tb_cmos_dvp_capture
// Three instances (SKIP_FRAMES = 0, 1, 2) share one sensor stimulus stream.
// A line-level model predicts the pixels and line_err of the SKIP=0 instance.
module tb_cmos_dvp_capture;

  localparam int H = 16;
  localparam int V = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_data = 8'h00;

  logic [15:0] dout0, dout1, dout2;
  logic        en0, en1, en2;
  logic        vs0, vs1, vs2;
  logic [7:0]  fcnt0, fcnt1, fcnt2;
  logic        lerr0, lerr1, lerr2;

  always #5 clk = ~clk;

  cmos_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(0)) dut0 (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .fifo_data_out(dout0), .fifo_data_en(en0),
    .fifo_data_vs(vs0), .frame_cnt(fcnt0), .line_err(lerr0)
  );

  cmos_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(1)) dut1 (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .fifo_data_out(dout1), .fifo_data_en(en1),
    .fifo_data_vs(vs1), .frame_cnt(fcnt1), .line_err(lerr1)
  );

  cmos_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2)) dut2 (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .fifo_data_out(dout2), .fifo_data_en(en2),
    .fifo_data_vs(vs2), .frame_cnt(fcnt2), .line_err(lerr2)
  );

  typedef struct {
    int nbytes;
    int nlines;
    int exp_strobes;
    int exp_err;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] pix2_q[$];
  logic [7:0]  line_buf[$];
  int          n_en0 = 0, n_en1 = 0, n_en2 = 0, b2b = 0;
  logic        vs_seen1 = 1'b0, vs_seen2 = 1'b0;

  // Line-level model state for the SKIP=0 instance.
  int          m_y = 0;
  logic        m_err = 1'b0;
  logic [7:0]  m_fcnt = 8'h00;
  logic [7:0]  ramp_b = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: pixel scoreboard for dut0, strobe counters, sync flags.
  initial begin : monitor
    logic p0, p1, p2;
    p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
    forever begin
      @(negedge clk);
      if (en0 === 1'b1) begin
        n_en0++;
        check("dut0_pixel_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("dut0_pixel", dout0, exp_q.pop_front());
      end
      if (en1 === 1'b1) n_en1++;
      if (en2 === 1'b1) begin
        n_en2++;
        pix2_q.push_back(dout2);
      end
      if (vs1 === 1'b1) vs_seen1 = 1'b1;
      if (vs2 === 1'b1) vs_seen2 = 1'b1;
      if ((en0 === 1'b1 && p0) || (en1 === 1'b1 && p1) || (en2 === 1'b1 && p2)) b2b++;
      p0 = (en0 === 1'b1);
      p1 = (en1 === 1'b1);
      p2 = (en2 === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic m_frame_start();
    m_y    = 0;
    m_err  = 1'b0;
    m_fcnt = m_fcnt + 8'd1;
  endtask

  // Expected pixels and error for one line held in line_buf.
  task automatic m_line();
    int n = line_buf.size();
    int npix = n / 2;
    if (npix > H) npix = H;
    if (m_y < V) begin
      for (int p = 0; p < npix; p++) exp_q.push_back({line_buf[2*p], line_buf[2*p+1]});
      if (npix < H) m_err = 1'b1;
      m_y++;
    end
    if (n % 2 == 1) m_err = 1'b1;
  endtask

  task automatic fill_random(input int n);
    line_buf.delete();
    for (int i = 0; i < n; i++) line_buf.push_back(8'($urandom));
  endtask

  task automatic vs_pulse();
    m_frame_start();
    cmos_href  = 1'b0;
    cmos_vsync = 1'b1;
    tick(); tick();
    cmos_vsync = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic send_line(input int n, input bit ramp);
    if (ramp) begin
      line_buf.delete();
      for (int i = 0; i < n; i++) begin
        line_buf.push_back(ramp_b);
        ramp_b = ramp_b + 8'd1;
      end
    end else begin
      fill_random(n);
    end
    m_line();
    for (int i = 0; i < n; i++) begin
      cmos_href = 1'b1;
      cmos_data = line_buf[i];
      tick();
    end
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    tick(); tick(); tick();
  endtask

  task automatic send_frame(input int nbytes, input int nlines, input bit ramp);
    if (ramp) ramp_b = 8'h00;
    vs_pulse();
    check("dut0_frame_cnt_at_vs", fcnt0, m_fcnt);
    check("dut0_line_err_cleared_at_vs", lerr0, 0);
    for (int l = 0; l < nlines; l++) send_line(nbytes, ramp);
  endtask

  initial begin : main
    vec_t tbl[6];
    int   base0, base1, base2;
    int   n;

    tbl[0] = '{2*H,      V,     H*V,       0};
    tbl[1] = '{2*H + 40, V + 5, H*V,       0};
    tbl[2] = '{2*H + 1,  1,     H,         1};
    tbl[3] = '{2*H - 6,  V,     (H-3)*V,   1};
    tbl[4] = '{2*H,      V - 3, H*(V-3),   0};
    tbl[5] = '{7,        2,     3*2,       1};

    // Reset state.
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_dout0", dout0, 0);
    check("rst_en0", en0, 0);
    check("rst_vs0", vs0, 0);
    check("rst_fcnt0", fcnt0, 0);
    check("rst_lerr0", lerr0, 0);
    check("rst_en1", en1, 0);
    check("rst_en2", en2, 0);
    check("rst_fcnt2", fcnt2, 0);
    rst = 1'b0;
    tick();

    // Ramp frames: SKIP=2 forwards only the third frame.
    base1 = n_en1;
    base2 = n_en2;
    vs_seen2 = 1'b0;
    send_frame(2*H, V, 1'b1);
    send_frame(2*H, V, 1'b1);
    check("skip2_no_strobes", n_en2 - base2, 0);
    check("skip2_no_vs", vs_seen2, 0);
    pix2_q.delete();
    base2 = n_en2;
    send_frame(2*H, V, 1'b1);
    check("skip2_strobes", n_en2 - base2, H*V);
    check("skip2_first_pixel", (pix2_q.size() > 0) ? 32'(pix2_q[0]) : 32'hdead_beef, 32'h0001);
    check("skip2_second_pixel", (pix2_q.size() > 1) ? 32'(pix2_q[1]) : 32'hdead_beef, 32'h0203);
    check("skip2_vs_seen", vs_seen2, 1);
    check("skip2_frame_cnt", fcnt2, 1);
    check("skip2_line_err", lerr2, 0);
    check("skip1_frame_cnt", fcnt1, 2);
    check("skip1_strobes", n_en1 - base1, 2*H*V);

    // Table-driven frame shapes on the SKIP=0 instance.
    for (int i = 0; i < 6; i++) begin
      base0 = n_en0;
      send_frame(tbl[i].nbytes, tbl[i].nlines, 1'b0);
      check($sformatf("tbl%0d_strobes", i), n_en0 - base0, tbl[i].exp_strobes);
      check($sformatf("tbl%0d_line_err", i), lerr0, tbl[i].exp_err);
      check($sformatf("tbl%0d_line_err_model", i), lerr0, m_err);
      check($sformatf("tbl%0d_pixels_drained", i), exp_q.size(), 0);
    end

    // vsync-to-fifo_data_vs lag (previous frame left line_err set).
    m_frame_start();
    cmos_vsync = 1'b1;
    tick();
    n = 1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (vs0 !== 1'b1 && n < 8);
    check("vs_lag_clocks", n, 2);
    check("vs_frame_cnt", fcnt0, m_fcnt);
    check("vs_line_err_cleared", lerr0, 0);
    cmos_vsync = 1'b0;
    tick(); tick();

    // Second-byte-to-strobe latency.
    line_buf.delete();
    line_buf.push_back(8'hA5);
    line_buf.push_back(8'h3C);
    m_line();
    cmos_href = 1'b1;
    cmos_data = 8'hA5;
    tick();
    cmos_data = 8'h3C;
    tick();
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    n = 1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (en0 !== 1'b1 && n < 8);
    check("pixel_latency_clocks", n, 2);
    check("pixel_latency_value", dout0, 16'hA53C);
    tick(); tick(); tick();
    check("short_line_err", lerr0, 1);

    // vsync rises mid-line at pixel 5 of line 5.
    vs_pulse();
    for (int l = 0; l < 5; l++) send_line(2*H, 1'b0);
    fill_random(2*H);
    for (int p = 0; p < 5; p++) exp_q.push_back({line_buf[2*p], line_buf[2*p+1]});
    base0 = n_en0;
    for (int i = 0; i < 2*H; i++) begin
      cmos_href = 1'b1;
      cmos_data = line_buf[i];
      if (i == 10) begin
        cmos_vsync = 1'b1;
        m_frame_start();
      end
      if (i == 14) cmos_vsync = 1'b0;
      tick();
    end
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    tick(); tick(); tick();
    check("midvs_partial_strobes", n_en0 - base0, 5);
    check("midvs_frame_cnt", fcnt0, m_fcnt);
    check("midvs_line_err", lerr0, 0);
    base0 = n_en0;
    for (int l = 0; l < V + 1; l++) send_line(2*H, 1'b0);
    check("midvs_next_frame_strobes", n_en0 - base0, H*V);
    check("midvs_next_line_err", lerr0, m_err);
    check("midvs_pixels_drained", exp_q.size(), 0);

    // Reset mid-line with a pixel in the output stage.
    vs_pulse();
    fill_random(2*H);
    for (int p = 0; p < 3; p++) exp_q.push_back({line_buf[2*p], line_buf[2*p+1]});
    for (int i = 0; i < 8; i++) begin
      cmos_href = 1'b1;
      cmos_data = line_buf[i];
      tick();
    end
    rst = 1'b1;
    cmos_data = line_buf[8];
    tick();
    check("midrst_en0", en0, 0);
    check("midrst_dout0", dout0, 0);
    check("midrst_vs0", vs0, 0);
    check("midrst_fcnt0", fcnt0, 0);
    check("midrst_lerr0", lerr0, 0);
    check("midrst_en1", en1, 0);
    check("midrst_fcnt1", fcnt1, 0);
    check("midrst_fcnt2", fcnt2, 0);
    tick();
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    tick();
    rst = 1'b0;
    m_fcnt = 8'h00;
    tick();
    check("midrst_pixels_drained", exp_q.size(), 0);

    // After reset: SKIP=1 skips the first vs, forwards on the second.
    vs_seen1 = 1'b0;
    vs_seen2 = 1'b0;
    base0 = n_en0;
    base1 = n_en1;
    base2 = n_en2;
    send_frame(2*H, V, 1'b0);
    check("post_rst_skip0_strobes", n_en0 - base0, H*V);
    check("post_rst_skip1_first_strobes", n_en1 - base1, 0);
    check("post_rst_skip1_first_vs", vs_seen1, 0);
    base1 = n_en1;
    send_frame(2*H, V, 1'b0);
    check("post_rst_skip1_second_strobes", n_en1 - base1, H*V);
    check("post_rst_skip1_second_vs", vs_seen1, 1);
    check("post_rst_skip1_frame_cnt", fcnt1, 1);
    check("post_rst_skip2_strobes", n_en2 - base2, 0);
    check("post_rst_skip2_vs", vs_seen2, 0);

    check("no_back_to_back_strobes", b2b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
